// File: rtl/pid_sched_pkg.sv
// Shared types and defaults for the time-multiplexed pid scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pid_sched_pkg;

  // Scheduler transaction phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_W       = 16;
  localparam int DEF_TIMEOUT = 32;

endpackage

// File: rtl/pid_rr_arbiter.sv
// Round-robin pick of the first pending channel at or after ptr, wrapping modulo NCH.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the parent decides when a grant is consumed and advances ptr.
module pid_rr_arbiter #(
  parameter int NCH = 4,
  parameter int IDW = 3
) (
  input  logic [NCH-1:0] pending,
  input  logic [IDW-1:0] ptr,
  output logic [NCH-1:0] grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Two passes: channels at/after ptr first, then the wrapped-around lower channels
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!any && pending[i] && (i >= int'(ptr))) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IDW'(i);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!any && pending[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/pid_scheduler.sv
// Shares one pid core among NCH loops: capture per-channel samples, round-robin issue, route results back by id.
// Latency: req to core_start 3 cycles when idle; core_valid to res_valid exactly 1 cycle.
// Backpressure: none upstream; a repeat req before service overwrites the sample and flags overrun. Optional PID_SCHED_SAT_EN adds result clamping and sat_flag.
module pid_scheduler
  import pid_sched_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int IDW     = 3
`ifdef PID_SCHED_SAT_EN
  ,
  parameter logic [W-1:0] OUT_MIN = W'(16'h0000),
  parameter logic [W-1:0] OUT_MAX = W'(16'h00FF)
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   req,
  input  logic [NCH*W-1:0] meas,
  output logic [W-1:0]     core_in,
  output logic             core_start,
  input  logic [W-1:0]     core_out,
  input  logic             core_valid,
  output logic [W-1:0]     res,
  output logic             res_valid,
  output logic [IDW-1:0]   res_id,
  output logic             busy,
  output logic [NCH-1:0]   overrun,
  output logic             timeout_err,
  input  logic             err_clr
`ifdef PID_SCHED_SAT_EN
  ,
  output logic             sat_flag
`endif
);

  localparam int            TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [NCH-1:0]   pending;
  logic [W-1:0]     sbuf [NCH];
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   g;
  logic [NCH-1:0]   gsel;
  logic [NCH-1:0]   grant;
  logic [IDW-1:0]   idx;
  logic             any;
  logic [NCH-1:0]   issue_clr;
  logic [W-1:0]     issue_dat;
  logic [TW-1:0]    timer;
  logic             accept;
  logic             timeout_evt;
  logic [W-1:0]     res_d;

  pid_rr_arbiter #(
    .NCH (NCH),
    .IDW (IDW)
  ) u_arb (
    .pending (pending),
    .ptr     (ptr),
    .grant   (grant),
    .idx     (idx),
    .any     (any)
  );

  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign issue_clr = (state == ISSUE) ? gsel : '0;

  // Next-state logic; a result is accepted only while waiting, stray core_valid is ignored
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      IDLE:  if (any) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (core_valid) begin
          state_nxt = DONE;
          accept    = 1'b1;
        end else if (timer == TLAST) begin
          state_nxt   = IDLE;
          timeout_evt = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One-hot mux of the granted channel's buffered sample
  always_comb begin
    issue_dat = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gsel[i]) issue_dat = issue_dat | sbuf[i];
    end
  end

`ifdef PID_SCHED_SAT_EN
  logic sat_d;
  logic sat_q;

  // Unsigned clamp of the core result into [OUT_MIN, OUT_MAX]
  always_comb begin
    res_d = core_out;
    sat_d = 1'b0;
    if (core_out < OUT_MIN) begin
      res_d = OUT_MIN;
      sat_d = 1'b1;
    end else if (core_out > OUT_MAX) begin
      res_d = OUT_MAX;
      sat_d = 1'b1;
    end
  end

  // Saturation indicator captured with the result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sat_q <= 1'b0;
    else if (accept) sat_q <= sat_d;
  end

  assign sat_flag = sat_q & res_valid;
`else
  assign res_d = core_out;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Sample capture: a new req always wins over the issue-time clear so no sample is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      overrun <= '0;
      for (int i = 0; i < NCH; i++) sbuf[i] <= '0;
    end else begin
      pending <= (pending & ~issue_clr) | req;
      overrun <= err_clr ? '0 : (overrun | (req & pending));
      for (int i = 0; i < NCH; i++) begin
        if (req[i]) sbuf[i] <= meas[i*W +: W];
      end
    end
  end

  // Latch the grant in IDLE and advance the round-robin pointer past it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr  <= '0;
      g    <= '0;
      gsel <= '0;
    end else if (state == IDLE && any) begin
      g    <= idx;
      gsel <= grant;
      ptr  <= (idx == IDW'(NCH - 1)) ? '0 : idx + IDW'(1);
    end
  end

  // Issue: present the sample with a one-cycle start pulse and run the answer timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_in    <= '0;
      core_start <= 1'b0;
      timer      <= '0;
    end else begin
      core_start <= (state == ISSUE);
      if (state == ISSUE) begin
        core_in <= issue_dat;
        timer   <= '0;
      end else if (state == WAIT) begin
        timer <= timer + TW'(1);
      end
    end
  end

  // Result routing and sticky timeout flag; err_clr beats a same-cycle set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res         <= '0;
      res_id      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        res    <= res_d;
        res_id <= g;
      end
      timeout_err <= err_clr ? 1'b0 : (timeout_err | timeout_evt);
    end
  end

endmodule

// File: tb/tb_pid_scheduler.sv
// Self-checking bench for pid_scheduler against a round-robin queue model.
// Latency: checks req->core_start and core_valid->res_valid timing.
// Backpressure: exercises overrun, timeout and mid-transaction reset.
module tb_pid_scheduler;

  localparam int NCH = 4;
  localparam int W = 16;
  localparam int TIMEOUT = 32;
  localparam int IDW = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   req;
  logic [NCH*W-1:0] meas;
  logic [W-1:0]     core_in;
  logic             core_start;
  logic [W-1:0]     core_out;
  logic             core_valid;
  logic [W-1:0]     res;
  logic             res_valid;
  logic [IDW-1:0]   res_id;
  logic             busy;
  logic [NCH-1:0]   overrun;
  logic             timeout_err;
  logic             err_clr;
`ifdef PID_SCHED_SAT_EN
  logic             sat_flag;
`endif

  pid_scheduler #(
    .NCH(NCH), .W(W), .TIMEOUT(TIMEOUT), .IDW(IDW)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .meas(meas),
    .core_in(core_in), .core_start(core_start),
    .core_out(core_out), .core_valid(core_valid),
    .res(res), .res_valid(res_valid), .res_id(res_id),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err),
    .err_clr(err_clr)
`ifdef PID_SCHED_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending set, rotating pointer, newest sample per channel, sticky overrun
  logic [NCH-1:0] mp;
  int             mptr;
  logic [W-1:0]   msamp [NCH];
  logic [NCH-1:0] mov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] exp_res(input logic [W-1:0] r);
`ifdef PID_SCHED_SAT_EN
    return (r > 16'h00FF) ? 16'h00FF : r;
`else
    return r;
`endif
  endfunction

  function automatic int next_grant();
    for (int k = 0; k < NCH; k++) begin
      if (mp[(mptr + k) % NCH]) return (mptr + k) % NCH;
    end
    return 0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req = '0; meas = '0; core_valid = 1'b0; core_out = '0; err_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    mp = '0; mptr = 0; mov = '0;
    for (int i = 0; i < NCH; i++) msamp[i] = '0;
    tick();
  endtask

  // One-cycle request pulse; random samples unless a fixed value is given
  task automatic send(input logic [NCH-1:0] mask, input bit rnd, input logic [W-1:0] val);
    logic [W-1:0] v;
    for (int i = 0; i < NCH; i++) begin
      if (mask[i]) begin
        v = rnd ? W'($urandom) : val;
        meas[i*W +: W] = v;
        if (mp[i]) mov[i] = 1'b1;
        mp[i] = 1'b1;
        msamp[i] = v;
      end
    end
    req = mask;
    tick();
    req = '0;
  endtask

  // Wait (bounded) for the next core_start and check it carries the model's granted sample
  task automatic serve_start(output int g);
    g = next_grant();
    mp[g] = 1'b0;
    mptr = (g + 1) % NCH;
    for (int i = 0; i < 40 && core_start !== 1'b1; i++) tick();
    chk("start_seen", core_start, 1);
    chk("core_in", core_in, msamp[g]);
    chk("busy_in_wait", busy, 1);
  endtask

  // Answer after d cycles and check the routed result
  task automatic finish(input int g, input int d, input logic [W-1:0] r);
    repeat (d) tick();
    core_valid = 1'b1;
    core_out = r;
    tick();
    core_valid = 1'b0;
    chk("res_valid_hi", res_valid, 1);
    chk("res", res, exp_res(r));
    chk("res_id", res_id, g);
`ifdef PID_SCHED_SAT_EN
    chk("sat_flag", sat_flag, (r > 16'h00FF) ? 1 : 0);
`endif
    tick();
    chk("res_valid_lo", res_valid, 0);
    chk("res_hold", res, exp_res(r));
  endtask

  initial begin
    int g;
    int g2;
    bit saw;
    logic [W-1:0] r;

    reset = 1'b1;
    req = '0; meas = '0; core_valid = 1'b0; core_out = '0; err_clr = 1'b0;

    // Reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_in", core_in, 0);
    chk("rst_res", res, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout_err, 0);

    // Single request on ch1: exact issue latency, answer 3 cycles after start
    send(4'b0010, 1'b0, 16'h00A5);
    chk("lat_idle_busy", busy, 0);
    tick();
    chk("lat_issue_busy", busy, 1);
    chk("lat_issue_nostart", core_start, 0);
    tick();
    serve_start(g);
    tick();
    chk("start_one_cycle", core_start, 0);
    finish(g, 2, 16'h0123);
    chk("core_in_hold", core_in, 16'h00A5);
    chk("idle_after", busy, 0);

    // All four at once from ptr=0, then a partial round
    do_reset();
    send(4'b1111, 1'b1, '0);
    repeat (4) begin
      serve_start(g);
      finish(g, $urandom_range(1, 4), W'($urandom));
    end
    send(4'b0011, 1'b1, '0);
    repeat (2) begin
      serve_start(g);
      finish(g, $urandom_range(1, 4), W'($urandom));
    end

    // Overrun on ch2 while ch0 is in flight; newest sample is issued once
    do_reset();
    send(4'b0001, 1'b1, '0);
    serve_start(g);
    send(4'b0100, 1'b0, 16'h0010);
    send(4'b0100, 1'b0, 16'h0020);
    chk("overrun_set", overrun, mov);
    finish(g, 2, W'($urandom));
    serve_start(g2);
    chk("overrun_ch2_sample", core_in, 16'h0020);
    finish(g2, 1, W'($urandom));
    saw = 1'b0;
    repeat (5) begin
      tick();
      if (core_start === 1'b1) saw = 1'b1;
    end
    chk("no_reissue", saw, 0);
    chk("overrun_sticky", overrun, mov);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    mov = '0;
    chk("overrun_clr", overrun, mov);

    // Timeout: ch0 never answered, ch1 is served afterwards
    do_reset();
    send(4'b0011, 1'b1, '0);
    serve_start(g);
    saw = 1'b0;
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      if (res_valid === 1'b1) saw = 1'b1;
    end
    chk("to_not_yet", timeout_err, 0);
    chk("to_busy_before", busy, 1);
    tick();
    chk("to_set", timeout_err, 1);
    chk("to_busy_drop", busy, 0);
    chk("to_no_res", saw | res_valid, 0);
    serve_start(g);
    finish(g, 2, W'($urandom));
    chk("to_sticky", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_clr", timeout_err, 0);

    // Asynchronous reset in WAIT, then a stray core_valid
    do_reset();
    send(4'b1000, 1'b1, '0);
    serve_start(g);
    finish(g, 1, 16'h00C3);
    send(4'b1000, 1'b1, '0);
    serve_start(g);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_core_start", core_start, 0);
    chk("ar_core_in", core_in, 0);
    chk("ar_res", res, 0);
    chk("ar_res_id", res_id, 0);
    chk("ar_res_valid", res_valid, 0);
    tick();
    reset = 1'b0;
    mp = '0; mptr = 0; mov = '0;
    tick();
    core_valid = 1'b1;
    core_out = 16'h7777;
    tick();
    core_valid = 1'b0;
    chk("stray_res_valid", res_valid, 0);
    chk("stray_busy", busy, 0);
    tick();
    chk("stray_res", res, 0);

    // Clamp boundary values (pass through unchanged when clamping is not built in)
    send(4'b0001, 1'b1, '0);
    serve_start(g);
    finish(g, 1, 16'h01E7);
    send(4'b0001, 1'b1, '0);
    serve_start(g);
    finish(g, 1, 16'h00B5);

    // Random rounds against the model
    for (int rnd = 0; rnd < 10; rnd++) begin
      send(NCH'($urandom_range(1, (1 << NCH) - 1)), 1'b1, '0);
      while (mp != '0) begin
        serve_start(g);
        r = W'($urandom);
        finish(g, $urandom_range(0, 5), r);
      end
      chk("rnd_idle", busy, 0);
      chk("rnd_overrun", overrun, mov);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
